// File: rtl/i2c_byte_sequencer.sv
// Byte-level I2C command sequencer: turns start/stop/read/write requests into
// a stream of bit-level commands for a bit controller and collects the results.
module i2c_byte_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic [3:0] bit_cmd,
  output logic       bit_din,
  input  logic       bit_ack,
  input  logic       bit_dout,
  input  logic       i2c_al
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_READ,
    ST_ACK,
    ST_STOP
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] bit_cmd_reg, bit_cmd_next;
  logic       bit_din_reg, bit_din_next;
  logic       cmd_ack_reg, cmd_ack_next;
  logic       ack_out_reg, ack_out_next;
  logic [7:0] sr_reg, sr_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       wr_byte_reg, wr_byte_next;
  logic       go;

  // A request raised while its completion pulse is still visible is the old one.
  assign go = (start | stop | read | write) & ~cmd_ack_reg;

  always_comb begin
    state_next   = state_reg;
    bit_cmd_next = bit_cmd_reg;
    bit_din_next = bit_din_reg;
    cmd_ack_next = 1'b0;
    ack_out_next = ack_out_reg;
    sr_next      = sr_reg;
    cnt_next     = cnt_reg;
    wr_byte_next = wr_byte_reg;

    if (i2c_al) begin
      state_next   = ST_IDLE;
      bit_cmd_next = CMD_NOP;
      cnt_next     = 3'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (go) begin
            sr_next      = din;
            cnt_next     = 3'd7;
            // read wins over write when both are requested
            wr_byte_next = ~read;
            if (start) begin
              state_next   = ST_START;
              bit_cmd_next = CMD_START;
            end else if (read) begin
              state_next   = ST_READ;
              bit_cmd_next = CMD_READ;
            end else if (write) begin
              state_next   = ST_WRITE;
              bit_cmd_next = CMD_WRITE;
              bit_din_next = din[7];
            end else begin
              state_next   = ST_STOP;
              bit_cmd_next = CMD_STOP;
            end
          end
        end

        ST_START: begin
          if (bit_ack) begin
            if (read) begin
              state_next   = ST_READ;
              bit_cmd_next = CMD_READ;
            end else begin
              state_next   = ST_WRITE;
              bit_cmd_next = CMD_WRITE;
              bit_din_next = sr_reg[7];
            end
          end
        end

        ST_WRITE: begin
          if (bit_ack) begin
            sr_next = {sr_reg[6:0], 1'b0};
            if (cnt_reg == 3'd0) begin
              state_next   = ST_ACK;
              bit_cmd_next = CMD_READ;
            end else begin
              cnt_next     = cnt_reg - 3'd1;
              bit_cmd_next = CMD_WRITE;
              bit_din_next = sr_reg[6];
            end
          end
        end

        ST_READ: begin
          if (bit_ack) begin
            sr_next = {sr_reg[6:0], bit_dout};
            if (cnt_reg == 3'd0) begin
              state_next   = ST_ACK;
              bit_cmd_next = CMD_WRITE;
              bit_din_next = ack_in;
            end else begin
              cnt_next     = cnt_reg - 3'd1;
              bit_cmd_next = CMD_READ;
            end
          end
        end

        ST_ACK: begin
          if (bit_ack) begin
            if (wr_byte_reg) begin
              ack_out_next = bit_dout;
            end
            if (stop) begin
              state_next   = ST_STOP;
              bit_cmd_next = CMD_STOP;
            end else begin
              state_next   = ST_IDLE;
              bit_cmd_next = CMD_NOP;
              cmd_ack_next = 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (bit_ack) begin
            state_next   = ST_IDLE;
            bit_cmd_next = CMD_NOP;
            cmd_ack_next = 1'b1;
          end
        end

        default: begin
          state_next   = ST_IDLE;
          bit_cmd_next = CMD_NOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      bit_cmd_reg <= CMD_NOP;
      bit_din_reg <= 1'b0;
      cmd_ack_reg <= 1'b0;
      ack_out_reg <= 1'b0;
      sr_reg      <= 8'h00;
      cnt_reg     <= 3'd0;
      wr_byte_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cmd_reg <= bit_cmd_next;
      bit_din_reg <= bit_din_next;
      cmd_ack_reg <= cmd_ack_next;
      ack_out_reg <= ack_out_next;
      sr_reg      <= sr_next;
      cnt_reg     <= cnt_next;
      wr_byte_reg <= wr_byte_next;
    end
  end

  assign bit_cmd = bit_cmd_reg;
  assign bit_din = bit_din_reg;
  assign cmd_ack = cmd_ack_reg;
  assign ack_out = ack_out_reg;
  assign dout    = sr_reg;

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Bench for i2c_byte_sequencer: emulates the bit controller and slave, and
// compares every transaction against a command-list model of the byte protocol.
module tb_i2c_byte_sequencer;

  localparam logic [3:0] C_NOP   = 4'b0000;
  localparam logic [3:0] C_START = 4'b0001;
  localparam logic [3:0] C_STOP  = 4'b0010;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_READ  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst, start, stop, read, write, ack_in;
  logic [7:0] din;
  logic       cmd_ack, ack_out;
  logic [7:0] dout;
  logic [3:0] bit_cmd;
  logic       bit_din, bit_ack, bit_dout, i2c_al;

  int checks = 0;
  int errors = 0;
  logic mdl_ack_out;

  logic [3:0] cmd_log[$];
  logic       din_log[$];
  logic [3:0] exp_cmd[$];
  logic       exp_din[$];

  i2c_byte_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .read(read), .write(write),
    .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout),
    .bit_cmd(bit_cmd), .bit_din(bit_din), .bit_ack(bit_ack), .bit_dout(bit_dout),
    .i2c_al(i2c_al)
  );

  always #5 clk = ~clk;

  // Expected bit-command list of one byte transaction, from the protocol rules.
  task automatic build_expected(input logic s, p, r, w, input logic [7:0] d, input logic ai);
    exp_cmd.delete();
    exp_din.delete();
    if (!s && !r && !w) begin
      exp_cmd.push_back(C_STOP);
    end else begin
      if (s) exp_cmd.push_back(C_START);
      if (r) begin
        for (int i = 0; i < 8; i++) exp_cmd.push_back(C_READ);
        exp_cmd.push_back(C_WRITE);
        exp_din.push_back(ai);
      end else begin
        for (int i = 7; i >= 0; i--) begin
          exp_cmd.push_back(C_WRITE);
          exp_din.push_back(d[i]);
        end
        exp_cmd.push_back(C_READ);
      end
      if (p) exp_cmd.push_back(C_STOP);
    end
  endtask

  // abort_kind: 0 none, 1 arbitration loss, 2 reset; triggered when the command
  // following the abort_after-th acknowledged abort_cmd appears.
  task automatic run_txn(input string name, input logic s, p, r, w, input logic [7:0] d,
                         input logic ai, input logic [7:0] sbyte, input logic sack,
                         input int abort_kind, input logic [3:0] abort_cmd, input int abort_after);
    bit   have = 0, done = 0, just = 0, aborted = 0, lat_ok = 0;
    int   wait_c = 0, rd_idx = 0, type_cnt = 0, nack = 0;
    logic [7:0] prev_dout;
    logic wr_din[$];

    build_expected(s, p, r, w, d, ai);
    cmd_log.delete();
    din_log.delete();
    start = s; stop = p; read = r; write = w; din = d; ack_in = ai;

    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      just = bit_ack;
      bit_ack = 1'b0;
      if (just) have = 0;
      if (cmd_ack) begin
        lat_ok = just;
        done = 1;
      end else if (bit_cmd != C_NOP) begin
        if (!have && abort_kind != 0 && type_cnt == abort_after) begin
          prev_dout = dout;
          if (abort_kind == 1) i2c_al = 1'b1; else rst = 1'b1;
          bit_ack = 1'b1;
          @(negedge clk);
          i2c_al = 1'b0; rst = 1'b0; bit_ack = 1'b0;
          start = 0; stop = 0; read = 0; write = 0;
          checks++;
          if (bit_cmd !== C_NOP || cmd_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s abort: bit_cmd=%b cmd_ack=%b, required 0000/0", name, bit_cmd, cmd_ack);
          end
          if (abort_kind == 1) begin
            checks++;
            if (dout !== prev_dout || ack_out !== mdl_ack_out) begin
              errors++;
              $display("FAIL %s al_keep: dout=%h ack_out=%b, required %h/%b", name, dout, ack_out, prev_dout, mdl_ack_out);
            end
          end else begin
            mdl_ack_out = 1'b0;
            checks++;
            if (dout !== 8'h00 || ack_out !== 1'b0 || bit_din !== 1'b0) begin
              errors++;
              $display("FAIL %s rst_values: dout=%h ack_out=%b bit_din=%b, required 00/0/0", name, dout, ack_out, bit_din);
            end
          end
          for (int k = 0; k < 4; k++) begin
            bit_ack = (k == 0);
            @(negedge clk);
            bit_ack = 1'b0;
            checks++;
            if (cmd_ack !== 1'b0 || bit_cmd !== C_NOP) begin
              errors++;
              $display("FAIL %s post_abort[%0d]: cmd_ack=%b bit_cmd=%b, required 0/0000", name, k, cmd_ack, bit_cmd);
            end
          end
          aborted = 1;
          done = 1;
        end else begin
          if (!have) begin
            have = 1;
            cmd_log.push_back(bit_cmd);
            din_log.push_back(bit_din);
            wait_c = $urandom_range(0, 2);
          end else begin
            checks++;
            if (bit_cmd !== cmd_log[$]) begin
              errors++;
              $display("FAIL %s hold: bit_cmd=%b, required %b", name, bit_cmd, cmd_log[$]);
            end
          end
          if (wait_c == 0) begin
            if (bit_cmd == C_READ) begin
              if (r) begin
                bit_dout = (rd_idx < 8) ? sbyte[3'(7 - rd_idx)] : 1'b0;
                rd_idx++;
              end else begin
                bit_dout = sack;
              end
            end else begin
              bit_dout = 1'($urandom_range(0, 1));
            end
            if (bit_cmd == abort_cmd) type_cnt++;
            bit_ack = 1'b1;
            nack++;
          end else begin
            wait_c--;
          end
        end
      end
    end

    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: no cmd_ack within budget, required one", name);
      start = 0; stop = 0; read = 0; write = 0;
    end else if (!aborted) begin
      if (!r && (s || w)) mdl_ack_out = sack;
      checks++;
      if (!lat_ok) begin
        errors++;
        $display("FAIL %s latency: cmd_ack not one cycle after last bit_ack", name);
      end
      checks++;
      if (cmd_log.size() != exp_cmd.size() || nack != exp_cmd.size()) begin
        errors++;
        $display("FAIL %s cmd_count: got %0d cmds %0d acks, required %0d", name, cmd_log.size(), nack, exp_cmd.size());
      end else begin
        for (int i = 0; i < exp_cmd.size(); i++) begin
          checks++;
          if (cmd_log[i] !== exp_cmd[i]) begin
            errors++;
            $display("FAIL %s cmd[%0d]: got %b, required %b", name, i, cmd_log[i], exp_cmd[i]);
          end
          if (cmd_log[i] == C_WRITE) wr_din.push_back(din_log[i]);
        end
        checks++;
        if (wr_din != exp_din) begin
          errors++;
          $display("FAIL %s bit_din: got %p, required %p", name, wr_din, exp_din);
        end
      end
      if (r) begin
        checks++;
        if (dout !== sbyte) begin
          errors++;
          $display("FAIL %s dout: got %h, required %h", name, dout, sbyte);
        end
      end
      checks++;
      if (ack_out !== mdl_ack_out) begin
        errors++;
        $display("FAIL %s ack_out: got %b, required %b", name, ack_out, mdl_ack_out);
      end
      // flags stay up through the cmd_ack cycle; nothing new may start
      @(negedge clk);
      start = 0; stop = 0; read = 0; write = 0;
      checks++;
      if (cmd_ack !== 1'b0 || bit_cmd !== C_NOP) begin
        errors++;
        $display("FAIL %s after_ack: cmd_ack=%b bit_cmd=%b, required 0/0000", name, cmd_ack, bit_cmd);
      end
    end
    $display("txn %s: s=%b p=%b r=%b w=%b din=%h cmds=%0d acks=%0d dout=%h ack_out=%b",
             name, s, p, r, w, d, cmd_log.size(), nack, dout, ack_out);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bit_cmd !== 4'b0000 || bit_din !== 1'b0 || cmd_ack !== 1'b0 || ack_out !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset: bit_cmd=%b bit_din=%b cmd_ack=%b ack_out=%b dout=%h, required all zero",
               bit_cmd, bit_din, cmd_ack, ack_out, dout);
    end
    rst = 1'b0;
    mdl_ack_out = 1'b0;
    bit_ack = 1'b1;
    @(negedge clk);
    bit_ack = 1'b0;
    checks++;
    if (bit_cmd !== C_NOP || cmd_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_stray_ack: bit_cmd=%b cmd_ack=%b, required 0000/0", bit_cmd, cmd_ack);
    end
    $display("txn reset: outputs checked");
  endtask

  task automatic test_write_start_stop;
    run_txn("write_start_stop", 1, 1, 0, 1, 8'hA5, 0, 8'h00, 1'b0, 0, C_NOP, 0);
  endtask

  task automatic test_read_nack;
    run_txn("write_nack_setup", 1, 0, 0, 1, 8'h3C, 0, 8'h00, 1'b1, 0, C_NOP, 0);
    run_txn("read_nack", 0, 0, 1, 0, 8'h00, 1, 8'h6C, 1'b0, 0, C_NOP, 0);
  endtask

  task automatic test_stop_only;
    run_txn("stop_only", 0, 1, 0, 0, 8'h00, 0, 8'h00, 1'b0, 0, C_NOP, 0);
  endtask

  task automatic test_arb_lost;
    run_txn("arb_lost", 1, 1, 0, 1, 8'hC3, 0, 8'h00, 1'b0, 1, C_WRITE, 3);
    run_txn("after_arb_lost", 1, 0, 1, 0, 8'h00, 0, 8'h9E, 1'b0, 0, C_NOP, 0);
  endtask

  task automatic test_reset_mid_read;
    run_txn("write_for_reset", 0, 0, 0, 1, 8'h81, 0, 8'h00, 1'b1, 0, C_NOP, 0);
    run_txn("reset_mid_read", 1, 1, 1, 0, 8'h00, 0, 8'hF0, 1'b0, 2, C_READ, 4);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 12; n++) begin
      int kind = $urandom_range(0, 4);
      logic s = 1'($urandom_range(0, 1));
      logic p = 1'($urandom_range(0, 1));
      logic [7:0] d = 8'($urandom);
      logic [7:0] sb = 8'($urandom);
      logic ai = 1'($urandom_range(0, 1));
      logic sk = 1'($urandom_range(0, 1));
      if (kind == 0)
        run_txn("rand_stop", 0, 1, 0, 0, d, ai, sb, sk, 0, C_NOP, 0);
      else if (kind <= 2)
        run_txn("rand_read", s, p, 1, 1'($urandom_range(0, 1)), d, ai, sb, sk, 0, C_NOP, 0);
      else
        run_txn("rand_write", s, p, 0, 1, d, ai, sb, sk, 0, C_NOP, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; read = 0; write = 0; ack_in = 0; din = 8'h00;
    bit_ack = 0; bit_dout = 0; i2c_al = 0; mdl_ack_out = 1'b0;
    test_reset();
    test_write_start_stop();
    test_read_nack();
    test_stop_only();
    test_arb_lost();
    test_reset_mid_read();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_byte_sequencer.md
I2C_BYTE_SEQUENCER -- requirements
Module: i2c_byte_sequencer

Interface
REQ-001 Parameters: none; byte width fixed at 8, MSB first.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset; overrides every other input.
REQ-005 start  in  1  requester flag: generate START before the byte.
REQ-006 stop  in  1  requester flag: generate STOP after the byte, or STOP alone.
REQ-007 read  in  1  requester flag: receive a byte.
REQ-008 write  in  1  requester flag: transmit din.
REQ-009 ack_in  in  1  ACK bit driven after a read (0 = ACK, 1 = NACK).
REQ-010 din  in  8  byte to transmit.
REQ-011 cmd_ack  out  1  one-cycle pulse on command completion.
REQ-012 ack_out  out  1  ACK bit sampled from the slave after a write.
REQ-013 dout  out  8  received byte.
REQ-014 bit_cmd  out  4  bit-level command: NOP 0000, START 0001, STOP 0010, WRITE 0100, READ 1000.
REQ-015 bit_din  out  1  bit to write with a WRITE bit command.
REQ-016 bit_ack  in  1  one-cycle pulse from the bit controller: current bit command is done.
REQ-017 bit_dout  in  1  bit sampled by the bit controller; valid with bit_ack.
REQ-018 i2c_al  in  1  arbitration-lost flag from the bit controller.

Function
REQ-019 The request handshake SHALL work as follows:
- go = (start|stop|read|write) & ~cmd_ack.
- The requester holds its flags and din stable until cmd_ack.
- go SHALL be ignored in the cycle cmd_ack is high.
REQ-020 The state machine SHALL have states IDLE, START, WRITE, READ, ACK and STOP, all registered; bit_cmd and bit_din update on the clock edge at which a transition is taken.
REQ-021 In IDLE on go, the block SHALL:
- load the shift register with din and set the bit counter to 7;
- select the next state by priority start > read > write > stop, issuing the matching bit_cmd.
REQ-022 bit_cmd SHALL hold its value until bit_ack; bit_ack SHALL be ignored in IDLE.
REQ-023 In START, on bit_ack the block SHALL go to READ (issue READ) if read is set, else to WRITE (issue WRITE).
REQ-024 In WRITE, bit_din SHALL equal shift-register bit 7. On each bit_ack:
- shift the register left by one;
- if counter = 0, go to ACK and issue READ; else decrement the counter and issue WRITE.
REQ-025 In READ, on each bit_ack the block SHALL shift bit_dout into bit 0.
- If counter = 0, go to ACK, issue WRITE with bit_din = ack_in.
- Else decrement the counter and issue READ.
REQ-026 In ACK, on bit_ack the block SHALL:
- capture ack_out <= bit_dout, but only when the byte was a write; ack_out holds otherwise;
- then go to STOP (issue STOP) if stop is set, else go to IDLE with bit_cmd = NOP and cmd_ack = 1.
REQ-027 In STOP, on bit_ack the block SHALL go to IDLE with bit_cmd = NOP and cmd_ack = 1.
REQ-028 cmd_ack SHALL be high exactly one cycle, the cycle after the final bit_ack (latency 1).
REQ-029 dout SHALL equal the shift register and be valid while cmd_ack is high after a read.
REQ-030 If i2c_al = 1 in any state, the block SHALL next cycle:
- set state IDLE, bit_cmd NOP, cmd_ack 0;
- clear the counter;
- keep dout and ack_out.
REQ-031 If i2c_al and bit_ack are high in the same cycle, i2c_al SHALL win.
REQ-032 Simultaneous read and write SHALL be treated as read.
REQ-033 A STOP-only request SHALL issue a single STOP bit command.

Reset
REQ-034 When rst = 1 at a clock edge, the block SHALL set state IDLE, bit_cmd 0000, bit_din 0, cmd_ack 0, ack_out 0, dout 0x00, shift register 0x00, counter 0.
REQ-035 Reset SHALL take effect mid-operation in any state, with priority over i2c_al and bit_ack; there SHALL be no completion pulse afterwards.

Verification
REQ-036 Write with start+stop: start=write=stop=1, din=0xA5, bit_ack each issued command, slave bit_dout=0 on the ACK read.
- Required: bit_cmd sequence START, WRITE x8, READ, STOP.
- Required: bit_din 1,0,1,0,0,1,0,1.
- Required: cmd_ack once, ack_out=0; 11 bit_acks total.
REQ-037 Read with NACK: read=1, ack_in=1, bit_dout stream 0,1,1,0,1,1,0,0.
- Required: READ x8, then WRITE with bit_din=1.
- Required: dout=0x6C at cmd_ack; ack_out unchanged.
REQ-038 Stop-only: stop=1.
- Required: single STOP bit command; cmd_ack one cycle after its bit_ack; no further bit_cmd while flags are held in the cmd_ack cycle.
REQ-039 Arbitration loss: assert i2c_al after the 3rd WRITE bit_ack.
- Required: next cycle IDLE, bit_cmd=0000, no cmd_ack.
- Required: a new go is accepted afterwards.
REQ-040 Reset mid-read: rst=1 after 4 READ bit_acks.
- Required: all outputs at reset values next cycle.
- Required: no cmd_ack; a stray bit_ack in IDLE is ignored.
